conv_output_agc: RTL and testbench
==================================

Name: conv_output_agc

Overview:
Downstream of the convolution stage. Consumes the 48-bit signed convolution result and its one-cycle valid strobe, and produces a saturated 16-bit signed sample for the pdm/speaker mux and the seven-segment display. A power-of-two gain (arithmetic right shift) adapts automatically: fast attack on clipping, slow release per window. A manual override is available.

Parameters:
WINDOW_SAMPLES, 24000, accepted samples per release-evaluation window (1 s at 24 kHz)
INIT_SHIFT, 24, shift value after reset
MIN_SHIFT, 8, lower bound of the adaptive shift
MAX_SHIFT, 40, upper bound of the adaptive shift
RELEASE_THRESH, 8192, window peak magnitude below which the shift decrements

Ports:
audio_clk  input  1  system audio clock (98.3 MHz)
rst_in  input  1  asynchronous active-high reset
conv_in  input  48  signed convolution result
conv_valid_in  input  1  one-cycle strobe qualifying conv_in
manual_en  input  1  1 = use manual_shift; adaptive state frozen
manual_shift  input  6  manual shift amount; clamped to [MIN_SHIFT, MAX_SHIFT]
audio_out  output  16  signed saturated output sample, held between strobes
audio_valid_out  output  1  one-cycle strobe, 2 cycles after conv_valid_in
shift_out  output  6  current adaptive shift register
clip_count  output  16  number of clipped samples; saturates at 65535

Behaviour:
- Reset (async, any time): audio_out=0, audio_valid_out=0, shift_out=INIT_SHIFT, clip_count=0. Window counter=0, window peak=0, window_clipped=0. Both pipeline valids cleared, so in-flight samples are dropped.
- Effective shift: manual_en ? clamp(manual_shift) : shift register. It is sampled in the same cycle the input is accepted.
- Stage 1, on cycle t with conv_valid_in=1:
  - s = conv_in >>> eff_shift, sign-preserving, 48-bit.
  - Register s and valid1.
  - clip = (s > 32767) || (s < -32768).
  - mag = min(|s|, 32767); -32768 counts as magnitude 32767.
- Stage 2, cycle t+1:
  - audio_out <= s > 32767 ? 32767 : s < -32768 ? -32768 : s[15:0].
  - audio_valid_out pulses high at t+2 for exactly one cycle.
- Back-to-back strobes on every cycle are supported at full throughput.
- Adaptive update (manual_en=0 only), applied at the end of the accepting cycle. The next accepted sample sees the new shift.
  - Attack: if clip, then shift++ (held at MAX_SHIFT) and window_clipped<=1.
  - Window: the counter increments per accepted sample. The peak register holds max(peak, mag).
  - On the sample where counter == WINDOW_SAMPLES-1:
    - If !window_clipped, !clip and max(peak, mag) < RELEASE_THRESH, then shift-- (held at MIN_SHIFT).
    - Counter, peak and window_clipped then clear.
  - If clip occurs on the last window sample, attack wins: shift increments, no decrement, and the window still clears.
- clip_count increments on every clipped sample in both modes and saturates at 65535.
- manual_en=1 freezes the shift, counter, peak and window_clipped. Deasserting manual_en resumes the window where it was frozen.
- Changing manual_shift between strobes has no effect on samples already in the pipeline.
- conv_valid_in=0 leaves all state unchanged, and audio_out holds its last value.

Test Plan:
- Reset, then 3 strobes of conv_in=2^40, adaptive mode:
  - audio_out = 32767, 32767, 16384.
  - shift_out = 25, then 26, then stays 26.
  - clip_count = 2.
  - Each audio_valid_out arrives exactly 2 cycles after its strobe.
- Strobe conv_in=-2^39 at shift 24 -> audio_out = -32768, no clip, shift stays 24.
- Strobe conv_in=-2^41 at shift 24 -> audio_out = -32768, clip_count +1, shift 25.
- WINDOW_SAMPLES=4: four strobes of 2^30 at shift 24 (value 64) -> shift 23 after the 4th strobe. Four more -> shift 22.
- WINDOW_SAMPLES=4: values 64, 64, 64, then 2^41 on the 4th sample -> shift 25 (attack wins), window cleared. Next four small samples -> shift 24.
- manual_en=1, manual_shift=63, conv_in=2^45 -> effective shift 40, audio_out = 32. shift_out unchanged.
- Assert rst_in one cycle after a strobe -> no audio_valid_out pulse. All outputs return to their reset values immediately.

Source files
------------

// File: rtl/conv_output_agc_if.sv
// Valid-qualified sample stream: a data word plus its one-cycle strobe.
interface conv_output_agc_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] data;
    logic                    valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);
endinterface

// File: rtl/conv_output_agc.sv
// Output AGC for the convolution result: power-of-two gain with fast attack /
// windowed release, 16-bit saturation, and a clamped manual override.
module conv_output_agc #(
    parameter int WINDOW_SAMPLES = 24000,
    parameter int INIT_SHIFT     = 24,
    parameter int MIN_SHIFT      = 8,
    parameter int MAX_SHIFT      = 40,
    parameter int RELEASE_THRESH = 8192
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    conv_output_agc_if.slave   conv,
    conv_output_agc_if.master  audio,
    input  logic               manual_en,
    input  logic [5:0]         manual_shift,
    output logic [5:0]         shift_out,
    output logic [15:0]        clip_count
);
    localparam int CNT_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_SAMPLES - 1);
    localparam logic [5:0] MIN_SH  = 6'(MIN_SHIFT);
    localparam logic [5:0] MAX_SH  = 6'(MAX_SHIFT);
    localparam logic [5:0] INIT_SH = 6'(INIT_SHIFT);
    localparam logic signed [47:0] POS_MAX = 48'sd32767;
    localparam logic signed [47:0] NEG_MIN = -48'sd32768;
    localparam logic signed [47:0] NEG_MAG = -48'sd32767;

    logic [5:0]         shift_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [14:0]        peak_r;
    logic               win_clipped_r;
    logic signed [47:0] s_q;
    logic               valid1_q;

    logic [5:0]         eff_shift;
    logic signed [47:0] s_comb;
    logic               clip;
    logic [14:0]        mag;
    logic [14:0]        peak_max;
    logic               last_sample;
    logic               do_release;
    logic signed [15:0] sat_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        eff_shift = shift_r;
        if (manual_en) begin
            if (manual_shift < MIN_SH)      eff_shift = MIN_SH;
            else if (manual_shift > MAX_SH) eff_shift = MAX_SH;
            else                            eff_shift = manual_shift;
        end

        s_comb = conv.data >>> eff_shift;
        clip   = (s_comb > POS_MAX) || (s_comb < NEG_MIN);

        // -32768 is folded into 32767 so the peak fits 15 bits.
        mag = 15'h7fff;
        if (s_comb <= POS_MAX && s_comb >= NEG_MAG) begin
            if (s_comb < 0) mag = 15'(-s_comb);
            else            mag = 15'(s_comb);
        end

        peak_max    = (mag > peak_r) ? mag : peak_r;
        last_sample = (cnt_r == LAST_CNT);
        do_release  = !win_clipped_r && !clip && (int'(peak_max) < RELEASE_THRESH);

        sat_q = s_q[15:0];
        if (s_q > POS_MAX)      sat_q = 16'sh7fff;
        else if (s_q < NEG_MIN) sat_q = 16'sh8000;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            s_q         <= '0;
            valid1_q    <= 1'b0;
            audio.data  <= '0;
            audio.valid <= 1'b0;
            clip_count  <= '0;
        end else begin
            valid1_q    <= conv.valid;
            audio.valid <= valid1_q;
            if (conv.valid) s_q <= s_comb;
            if (valid1_q)   audio.data <= sat_q;
            if (conv.valid && clip && clip_count != 16'hffff)
                clip_count <= clip_count + 16'd1;
        end
    end

    // Adaptive gain: frozen while the manual override is active.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            shift_r       <= INIT_SH;
            cnt_r         <= '0;
            peak_r        <= '0;
            win_clipped_r <= 1'b0;
        end else if (conv.valid && !manual_en) begin
            if (clip) begin
                if (shift_r < MAX_SH) shift_r <= shift_r + 6'd1;
            end else if (last_sample && do_release && shift_r > MIN_SH) begin
                shift_r <= shift_r - 6'd1;
            end

            if (last_sample) begin
                cnt_r         <= '0;
                peak_r        <= '0;
                win_clipped_r <= 1'b0;
            end else begin
                cnt_r         <= cnt_r + 1'b1;
                peak_r        <= peak_max;
                win_clipped_r <= win_clipped_r | clip;
            end
        end
    end

    assign shift_out = shift_r;

endmodule

// File: tb/tb_conv_output_agc.sv
// Directed bench for conv_output_agc with a 4-sample release window.
module tb_conv_output_agc;
    logic        audio_clk = 1'b0;
    logic        rst_in;
    logic        manual_en;
    logic [5:0]  manual_shift;
    logic [5:0]  shift_out;
    logic [15:0] clip_count;
    int          vectors    = 0;
    int          miscompares = 0;

    conv_output_agc_if #(.WIDTH(48)) conv_bus ();
    conv_output_agc_if #(.WIDTH(16)) audio_bus ();

    conv_output_agc #(.WINDOW_SAMPLES(4)) dut (
        .audio_clk   (audio_clk),
        .rst_in      (rst_in),
        .conv        (conv_bus),
        .audio       (audio_bus),
        .manual_en   (manual_en),
        .manual_shift(manual_shift),
        .shift_out   (shift_out),
        .clip_count  (clip_count)
    );

    always #5 audio_clk = ~audio_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge audio_clk);
        rst_in = 1'b1;
        @(negedge audio_clk);
        rst_in = 1'b0;
    endtask

    // One isolated strobe; checks the 2-cycle latency, one-cycle pulse and hold.
    task automatic send(input string tag, input logic [47:0] din, input logic [15:0] exp);
        @(negedge audio_clk);
        conv_bus.data  = din;
        conv_bus.valid = 1'b1;
        @(negedge audio_clk);
        conv_bus.valid = 1'b0;
        check({tag, "_early"}, {15'd0, audio_bus.valid}, 16'd0);
        @(negedge audio_clk);
        check({tag, "_valid"}, {15'd0, audio_bus.valid}, 16'd1);
        check({tag, "_data"}, audio_bus.data, exp);
        @(negedge audio_clk);
        check({tag, "_pulse"}, {15'd0, audio_bus.valid}, 16'd0);
        check({tag, "_hold"}, audio_bus.data, exp);
    endtask

    initial begin
        rst_in         = 1'b1;
        manual_en      = 1'b0;
        manual_shift   = 6'd0;
        conv_bus.data  = '0;
        conv_bus.valid = 1'b0;
        #12;
        check("rst_data",  audio_bus.data, 16'h0000);
        check("rst_valid", {15'd0, audio_bus.valid}, 16'd0);
        check("rst_shift", {10'd0, shift_out}, 16'd24);
        check("rst_clips", clip_count, 16'd0);
        do_reset();

        // Three back-to-back strobes of 2^40: attack twice, then in range.
        @(negedge audio_clk);
        conv_bus.data  = 48'h010000000000;
        conv_bus.valid = 1'b1;
        @(negedge audio_clk);
        check("b2b_shift1", {10'd0, shift_out}, 16'd25);
        check("b2b_early",  {15'd0, audio_bus.valid}, 16'd0);
        @(negedge audio_clk);
        check("b2b_v1",     {15'd0, audio_bus.valid}, 16'd1);
        check("b2b_d1",     audio_bus.data, 16'h7fff);
        check("b2b_shift2", {10'd0, shift_out}, 16'd26);
        @(negedge audio_clk);
        conv_bus.valid = 1'b0;
        check("b2b_v2",     {15'd0, audio_bus.valid}, 16'd1);
        check("b2b_d2",     audio_bus.data, 16'h7fff);
        check("b2b_shift3", {10'd0, shift_out}, 16'd26);
        @(negedge audio_clk);
        check("b2b_v3",     {15'd0, audio_bus.valid}, 16'd1);
        check("b2b_d3",     audio_bus.data, 16'h4000);
        check("b2b_clips",  clip_count, 16'd2);
        @(negedge audio_clk);
        check("b2b_end",    {15'd0, audio_bus.valid}, 16'd0);
        check("b2b_hold",   audio_bus.data, 16'h4000);

        // -2^39 >>> 24 is exactly -32768: no clip.
        do_reset();
        send("neg_edge", 48'hff8000000000, 16'h8000);
        check("neg_edge_shift", {10'd0, shift_out}, 16'd24);
        check("neg_edge_clips", clip_count, 16'd0);

        // -2^41 >>> 24 saturates negative and attacks.
        do_reset();
        send("neg_clip", 48'hfe0000000000, 16'h8000);
        check("neg_clip_shift", {10'd0, shift_out}, 16'd25);
        check("neg_clip_clips", clip_count, 16'd1);

        // Quiet windows release one step each.
        do_reset();
        for (int i = 0; i < 4; i++) send("rel1", 48'h000040000000, 16'd64);
        check("rel1_shift", {10'd0, shift_out}, 16'd23);
        for (int i = 0; i < 4; i++) send("rel2", 48'h000040000000, 16'd128);
        check("rel2_shift", {10'd0, shift_out}, 16'd22);

        // Clip on the last window sample: attack wins, window still clears.
        do_reset();
        for (int i = 0; i < 3; i++) send("late", 48'h000040000000, 16'd64);
        check("late_shift_pre", {10'd0, shift_out}, 16'd24);
        send("late_clip", 48'h020000000000, 16'h7fff);
        check("late_shift", {10'd0, shift_out}, 16'd25);
        for (int i = 0; i < 4; i++) send("after", 48'h000040000000, 16'd32);
        check("after_shift", {10'd0, shift_out}, 16'd24);

        // Manual override: shift clamped to 40 and 8, adaptive state frozen.
        do_reset();
        manual_en    = 1'b1;
        manual_shift = 6'd63;
        send("man_hi", 48'h200000000000, 16'd32);
        check("man_hi_shift", {10'd0, shift_out}, 16'd24);
        manual_shift = 6'd0;
        send("man_lo", 48'h000000100000, 16'd4096);
        send("man_clip", 48'h000001000000, 16'h7fff);
        check("man_clip_shift", {10'd0, shift_out}, 16'd24);
        check("man_clip_clips", clip_count, 16'd1);
        manual_en = 1'b0;

        // Reset one cycle after a strobe drops the in-flight sample.
        send("pre_rst", 48'h000040000000, 16'd64);
        @(negedge audio_clk);
        conv_bus.data  = 48'h020000000000;
        conv_bus.valid = 1'b1;
        @(negedge audio_clk);
        conv_bus.valid = 1'b0;
        check("mid_shift", {10'd0, shift_out}, 16'd25);
        rst_in = 1'b1;
        #1;
        check("mid_rst_data",  audio_bus.data, 16'h0000);
        check("mid_rst_shift", {10'd0, shift_out}, 16'd24);
        check("mid_rst_clips", clip_count, 16'd0);
        @(negedge audio_clk);
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge audio_clk);
            check("mid_rst_nopulse", {15'd0, audio_bus.valid}, 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
